// File: rtl/fmul_pkg.sv
// Shared types, widths and helpers for the FP32 multiplier arbiter.
package fmul_pkg;

    // Controller states: waiting for a request, holding operands on the
    // multicycle multiplier path, and presenting the registered result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int FP_W   = 32;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;

    // Quiet-free canonical NaN the shared multiplier returns for invalid operations.
    localparam logic [FP_W-1:0] FP_CANON_NAN = 32'h7F80_0001;

    // Classification of an IEEE-754 single value; the three flags never coexist.
    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } fp_flags_t;

    // Classify a single-precision value from its exponent and fraction fields.
    function automatic fp_flags_t fp_class(input logic [FP_W-1:0] value);
        logic [EXP_W-1:0]  exp_f;
        logic [FRAC_W-1:0] frac_f;
        logic              exp_ones;
        logic              exp_zero;
        logic              frac_zero;
        fp_flags_t         flags;
        exp_f     = value[FP_W-2 -: EXP_W];
        frac_f    = value[FRAC_W-1:0];
        exp_ones  = (exp_f == {EXP_W{1'b1}});
        exp_zero  = (exp_f == {EXP_W{1'b0}});
        frac_zero = (frac_f == {FRAC_W{1'b0}});
        flags.nan  = exp_ones && !frac_zero;
        flags.inf  = exp_ones && frac_zero;
        flags.zero = exp_zero && frac_zero;
        return flags;
    endfunction

endpackage

// File: rtl/fmul_arbiter_if.sv
// Request, multiplier and response signals of the shared FP32 multiplier
// arbiter. The slave modport is the arbiter's view; the master modport is
// the view of the clients plus the external multiplier.
interface fmul_arbiter_if
    import fmul_pkg::*;
#(
    parameter int N_REQ = 4
) ();

    localparam int ID_W = $clog2(N_REQ);

    // Per-requester request channels.
    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ-1:0]           req_ready;
    logic [N_REQ-1:0][FP_W-1:0] req_a;
    logic [N_REQ-1:0][FP_W-1:0] req_b;

    // Shared multiplier connection.
    logic [FP_W-1:0]            mul_a;
    logic [FP_W-1:0]            mul_b;
    logic [FP_W-1:0]            mul_op;

    // Single tagged response channel.
    logic                       resp_valid;
    logic                       resp_ready;
    logic [ID_W-1:0]            resp_id;
    logic [FP_W-1:0]            resp_data;
    logic                       resp_nan;
    logic                       resp_inf;
    logic                       resp_zero;
    logic                       busy;

    modport slave (
        input  req_valid, req_a, req_b, mul_op, resp_ready,
        output req_ready, mul_a, mul_b, resp_valid, resp_id, resp_data,
               resp_nan, resp_inf, resp_zero, busy
    );

    modport master (
        output req_valid, req_a, req_b, mul_op, resp_ready,
        input  req_ready, mul_a, mul_b, resp_valid, resp_id, resp_data,
               resp_nan, resp_inf, resp_zero, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: searches the request vector starting at ptr and
// wrapping modulo N_REQ, returning a one-hot grant and its index. The
// pointer itself is owned by the caller.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id
);

    // First requester at or after ptr wins; nothing is granted when disabled.
    always_comb begin
        int              pos_i;
        logic [ID_W-1:0] idx_s;
        logic            hit_s;
        logic            found_s;
        grant    = {N_REQ{1'b0}};
        grant_id = {ID_W{1'b0}};
        found_s  = 1'b0;
        pos_i    = 0;
        idx_s    = {ID_W{1'b0}};
        hit_s    = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            pos_i        = int'(ptr) + k;
            idx_s        = ID_W'((pos_i >= N_REQ) ? (pos_i - N_REQ) : pos_i);
            hit_s        = en && !found_s && req[idx_s];
            grant[idx_s] = grant[idx_s] | hit_s;
            grant_id     = hit_s ? idx_s : grant_id;
            found_s      = found_s | hit_s;
        end
    end

endmodule

// File: rtl/fmul_arbiter.sv
// Shares one external combinational FP32 multiplier between N_REQ clients.
// A round-robin winner's operands are latched and held on the multiplier
// inputs for MUL_LAT cycles, then the product is registered, classified and
// returned on a single response channel tagged with the winner's index.
module fmul_arbiter
    import fmul_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 2
) (
    input logic           clk,
    input logic           rst_n,
    fmul_arbiter_if.slave bus
);

    localparam int               ID_W     = $clog2(N_REQ);
    localparam int               CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [ID_W-1:0]  ptr_r;
    logic [ID_W-1:0]  ptr_nxt_s;
    logic [ID_W-1:0]  id_r;
    logic [CNT_W-1:0] cnt_r;
    logic [FP_W-1:0]  op_a_r;
    logic [FP_W-1:0]  op_b_r;
    logic [FP_W-1:0]  res_r;
    fp_flags_t        flags_r;

    logic [N_REQ-1:0] grant_s;
    logic [ID_W-1:0]  grant_id_s;
    logic             arb_en_s;
    logic             grant_any_s;
    logic             cnt_zero_s;

    // Grants only happen in IDLE; they are also suppressed while reset is
    // asserted so no client believes its request was taken by a block that
    // is about to clear itself.
    assign arb_en_s    = (state_r == IDLE) && rst_n;
    assign grant_any_s = |grant_s;
    assign cnt_zero_s  = (cnt_r == {CNT_W{1'b0}});

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .req      (bus.req_valid),
        .ptr      (ptr_r),
        .en       (arb_en_s),
        .grant    (grant_s),
        .grant_id (grant_id_s)
    );

    // Priority moves to the requester just after the winner, wrapping at N_REQ.
    always_comb begin
        ptr_nxt_s = ptr_r;
        if (grant_id_s == LAST_ID) begin
            ptr_nxt_s = {ID_W{1'b0}};
        end else begin
            ptr_nxt_s = grant_id_s + ID_W'(1);
        end
    end

    // Next-state logic for the grant / hold / respond sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_any_s) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HOLD: begin
                if (cnt_zero_s) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture on grant, hold countdown, and product capture at the end of HOLD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r   <= {ID_W{1'b0}};
            id_r    <= {ID_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            op_a_r  <= {FP_W{1'b0}};
            op_b_r  <= {FP_W{1'b0}};
            res_r   <= {FP_W{1'b0}};
            flags_r <= '{nan: 1'b0, inf: 1'b0, zero: 1'b0};
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_any_s) begin
                        op_a_r <= bus.req_a[grant_id_s];
                        op_b_r <= bus.req_b[grant_id_s];
                        id_r   <= grant_id_s;
                        cnt_r  <= CNT_LOAD;
                        ptr_r  <= ptr_nxt_s;
                    end
                end
                HOLD: begin
                    if (cnt_zero_s) begin
                        res_r   <= bus.mul_op;
                        flags_r <= fp_class(bus.mul_op);
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                RESP: begin
                    // Result and tag stay frozen until the consumer accepts.
                end
                default: begin
                end
            endcase
        end
    end

    // The multiplier always sees the operand registers, so its inputs only
    // toggle when a new operation is granted.
    assign bus.req_ready  = grant_s;
    assign bus.mul_a      = op_a_r;
    assign bus.mul_b      = op_b_r;
    assign bus.resp_valid = (state_r == RESP);
    assign bus.resp_id    = id_r;
    assign bus.resp_data  = res_r;
    assign bus.resp_nan   = flags_r.nan;
    assign bus.resp_inf   = flags_r.inf;
    assign bus.resp_zero  = flags_r.zero;
    assign bus.busy       = (state_r != IDLE);

endmodule
